// File: rtl/line_tap_buffer_if.sv
// Pixel-stream bundle for line_tap_buffer: raw pixels in, column-aligned
// current pixel plus previous-line taps out.
interface line_tap_buffer_if #(
    parameter int DATA_W   = 10,
    parameter int NUM_TAPS = 3,
    parameter int COL_W    = 11
);
    logic                       in_valid;
    logic [DATA_W-1:0]          in_data;
    logic                       in_sol;
    logic                       in_sof;
    logic                       out_valid;
    logic [DATA_W-1:0]          out_pix;
    logic [NUM_TAPS*DATA_W-1:0] out_taps;
    logic [NUM_TAPS-1:0]        out_taps_valid;
    logic [COL_W-1:0]           out_col;
    logic                       short_line;

    modport master (
        output in_valid, in_data, in_sol, in_sof,
        input  out_valid, out_pix, out_taps, out_taps_valid, out_col, short_line
    );

    modport slave (
        input  in_valid, in_data, in_sol, in_sof,
        output out_valid, out_pix, out_taps, out_taps_valid, out_col, short_line
    );
endinterface

// File: rtl/line_tap_buffer.sv
// Multi-line buffer: NUM_TAPS rotating line RAMs give each accepted pixel the
// same column from the previous NUM_TAPS lines, with per-tap validity.
module line_tap_buffer #(
    parameter int DATA_W   = 10,
    parameter int LINE_LEN = 1280,
    parameter int NUM_TAPS = 3,
    parameter int COL_W    = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    line_tap_buffer_if.slave   bus
);
    localparam int ADDR_W = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam int WSEL_W = $clog2(NUM_TAPS);
    localparam int LF_W   = $clog2(NUM_TAPS + 1);

    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(LINE_LEN - 1);
    localparam logic [WSEL_W-1:0] LAST_W   = WSEL_W'(NUM_TAPS - 1);
    localparam logic [LF_W-1:0]   FULL     = LF_W'(NUM_TAPS);

    function automatic logic [WSEL_W-1:0] next_w(input logic [WSEL_W-1:0] w);
        return (w == LAST_W) ? '0 : w + WSEL_W'(1);
    endfunction

    function automatic logic [LF_W-1:0] sat_inc(input logic [LF_W-1:0] lf);
        return (lf >= FULL) ? FULL : lf + LF_W'(1);
    endfunction

    logic [COL_W-1:0]  col;
    logic [WSEL_W-1:0] wsel;
    logic [LF_W-1:0]   lines_filled;

    logic [COL_W-1:0]  c_eff;
    logic [WSEL_W-1:0] w_eff;
    logic [LF_W-1:0]   lf_eff;
    logic              sol_cut;
    logic              end_of_line;
    logic [ADDR_W-1:0] addr;

    logic                       valid_q;
    logic [DATA_W-1:0]          pix_q;
    logic [COL_W-1:0]           col_q;
    logic [WSEL_W-1:0]          w_q;
    logic [NUM_TAPS-1:0]        tv_q;
    logic                       short_q;
    logic [NUM_TAPS*DATA_W-1:0] rd_all;
    logic [NUM_TAPS*DATA_W-1:0] taps;

    // sof restarts the frame; sol mid-line closes the current line before this pixel
    always_comb begin
        c_eff   = col;
        w_eff   = wsel;
        lf_eff  = lines_filled;
        sol_cut = 1'b0;
        if (bus.in_sof) begin
            c_eff  = '0;
            w_eff  = '0;
            lf_eff = '0;
        end else if (bus.in_sol && (col != '0)) begin
            c_eff   = '0;
            w_eff   = next_w(wsel);
            lf_eff  = sat_inc(lines_filled);
            sol_cut = 1'b1;
        end
        end_of_line = (c_eff == LAST_COL);
        addr        = c_eff[ADDR_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col          <= '0;
            wsel         <= '0;
            lines_filled <= '0;
        end else if (bus.in_valid) begin
            if (end_of_line) begin
                col          <= '0;
                wsel         <= next_w(w_eff);
                lines_filled <= sat_inc(lf_eff);
            end else begin
                col          <= c_eff + COL_W'(1);
                wsel         <= w_eff;
                lines_filled <= lf_eff;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            short_q <= 1'b0;
            pix_q   <= '0;
            col_q   <= '0;
            w_q     <= '0;
            tv_q    <= '0;
        end else begin
            valid_q <= bus.in_valid;
            short_q <= bus.in_valid & sol_cut;
            if (bus.in_valid) begin
                pix_q <= bus.in_data;
                col_q <= c_eff;
                w_q   <= w_eff;
                for (int j = 0; j < NUM_TAPS; j++) begin
                    tv_q[j] <= (lf_eff >= LF_W'(j + 1));
                end
            end
        end
    end

    // Each RAM is read every accepted pixel; the non-blocking write gives read-first.
    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_ram
        logic [DATA_W-1:0] mem [LINE_LEN];
        logic [DATA_W-1:0] rd_q;

        always_ff @(posedge clk) begin
            if (bus.in_valid && (w_eff == WSEL_W'(k))) begin
                mem[addr] <= bus.in_data;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_q <= '0;
            end else if (bus.in_valid) begin
                rd_q <= mem[addr];
            end
        end

        assign rd_all[k*DATA_W +: DATA_W] = rd_q;
    end

    // Tap j comes from the line written j lines before the current one.
    always_comb begin
        int src;
        src  = 0;
        taps = '0;
        for (int j = 1; j <= NUM_TAPS; j++) begin
            src = (int'(w_q) + NUM_TAPS - j) % NUM_TAPS;
            taps[(j-1)*DATA_W +: DATA_W] = rd_all[src*DATA_W +: DATA_W];
        end
    end

    assign bus.out_valid      = valid_q;
    assign bus.out_pix        = pix_q;
    assign bus.out_taps       = taps;
    assign bus.out_taps_valid = tv_q;
    assign bus.out_col        = col_q;
    assign bus.short_line     = short_q;

endmodule

// File: tb/tb_line_tap_buffer.sv
// Bench for line_tap_buffer: table-driven frame, hand sequences for line/frame
// sync corners and async reset, then random traffic against a line-history model.
module tb_line_tap_buffer;
    localparam int DATA_W   = 10;
    localparam int LINE_LEN = 8;
    localparam int NUM_TAPS = 3;
    localparam int COL_W    = 4;
    localparam int TW       = NUM_TAPS * DATA_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    line_tap_buffer_if #(.DATA_W(DATA_W), .NUM_TAPS(NUM_TAPS), .COL_W(COL_W)) bus ();

    line_tap_buffer #(
        .DATA_W(DATA_W), .LINE_LEN(LINE_LEN), .NUM_TAPS(NUM_TAPS), .COL_W(COL_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        logic              v;
        logic [DATA_W-1:0] d;
        logic              sol;
        logic              sof;
        logic [DATA_W-1:0] e_pix;
        logic [COL_W-1:0]  e_col;
        logic [TW-1:0]     e_taps;
        logic [NUM_TAPS-1:0] e_tv;
    } vec_t;

    vec_t vt [4*LINE_LEN];

    int errors = 0;
    int checks = 0;

    // Reference: frame = sequence of numbered lines; line n lives in slot n mod NUM_TAPS.
    int                m_col;
    int                m_line;
    logic [DATA_W-1:0] m_mem [NUM_TAPS][LINE_LEN];
    logic              exp_valid;
    logic              exp_short;
    logic [DATA_W-1:0] exp_pix;
    logic [COL_W-1:0]  exp_col;
    logic [TW-1:0]     exp_taps;
    logic [NUM_TAPS-1:0] exp_tv;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [TW-1:0] tv_mask(input logic [NUM_TAPS-1:0] tv);
        logic [TW-1:0] m;
        m = '0;
        for (int j = 0; j < NUM_TAPS; j++) begin
            if (tv[j]) m[j*DATA_W +: DATA_W] = '1;
        end
        return m;
    endfunction

    function automatic logic [DATA_W-1:0] tap(input int j);
        return bus.out_taps[(j-1)*DATA_W +: DATA_W];
    endfunction

    task automatic model_reset();
        m_col     = 0;
        m_line    = 0;
        exp_valid = 1'b0;
        exp_short = 1'b0;
        exp_pix   = '0;
        exp_col   = '0;
        exp_taps  = '0;
        exp_tv    = '0;
    endtask

    task automatic model_pixel(input logic [DATA_W-1:0] d, input logic sol, input logic sof);
        int slot;
        exp_short = 1'b0;
        if (sof) begin
            m_col  = 0;
            m_line = 0;
        end else if (sol && m_col != 0) begin
            m_line++;
            m_col     = 0;
            exp_short = 1'b1;
        end
        exp_valid = 1'b1;
        exp_pix   = d;
        exp_col   = COL_W'(m_col);
        for (int j = 1; j <= NUM_TAPS; j++) begin
            slot = ((m_line - j) % NUM_TAPS + NUM_TAPS) % NUM_TAPS;
            exp_taps[(j-1)*DATA_W +: DATA_W] = m_mem[slot][m_col];
            exp_tv[j-1] = (m_line >= j);
        end
        m_mem[m_line % NUM_TAPS][m_col] = d;
        m_col++;
        if (m_col == LINE_LEN) begin
            m_col = 0;
            m_line++;
        end
    endtask

    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic sol, input logic sof);
        logic [TW-1:0] mk;
        if (v) begin
            model_pixel(d, sol, sof);
        end else begin
            exp_valid = 1'b0;
            exp_short = 1'b0;
        end
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_sol   = sol;
        bus.in_sof   = sof;
        @(posedge clk);
        #1;
        chk("out_valid", 64'(bus.out_valid), 64'(exp_valid));
        chk("short_line", 64'(bus.short_line), 64'(exp_short));
        chk("out_pix", 64'(bus.out_pix), 64'(exp_pix));
        chk("out_col", 64'(bus.out_col), 64'(exp_col));
        chk("out_taps_valid", 64'(bus.out_taps_valid), 64'(exp_tv));
        mk = tv_mask(exp_tv);
        if (mk != '0) chk("out_taps", 64'(bus.out_taps & mk), 64'(exp_taps & mk));
    endtask

    task automatic send_line(input int line, input int first_col, input int ncols);
        for (int c = first_col; c < first_col + ncols; c++) begin
            step(1'b1, DATA_W'(line*16 + c), 1'b0, 1'b0);
        end
    endtask

    task automatic run_table(input bit with_idle);
        for (int k = 0; k < 4*LINE_LEN; k++) begin
            step(vt[k].v, vt[k].d, vt[k].sol, vt[k].sof);
            chk("tbl_pix", 64'(bus.out_pix), 64'(vt[k].e_pix));
            chk("tbl_col", 64'(bus.out_col), 64'(vt[k].e_col));
            chk("tbl_tv", 64'(bus.out_taps_valid), 64'(vt[k].e_tv));
            if (vt[k].e_tv != '0)
                chk("tbl_taps", 64'(bus.out_taps & tv_mask(vt[k].e_tv)), 64'(vt[k].e_taps & tv_mask(vt[k].e_tv)));
            if (with_idle) begin
                step(1'b0, DATA_W'($urandom), 1'b0, 1'b0);
                chk("idle_valid", 64'(bus.out_valid), 64'(0));
                chk("idle_pix_hold", 64'(bus.out_pix), 64'(vt[k].e_pix));
                chk("idle_col_hold", 64'(bus.out_col), 64'(vt[k].e_col));
            end
        end
    endtask

    initial begin
        int line, col, shorts;

        for (int k = 0; k < 4*LINE_LEN; k++) begin
            line = k / LINE_LEN;
            col  = k % LINE_LEN;
            vt[k].v     = 1'b1;
            vt[k].d     = DATA_W'(line*16 + col);
            vt[k].sol   = (col == 0);
            vt[k].sof   = (k == 0);
            vt[k].e_pix = DATA_W'(line*16 + col);
            vt[k].e_col = COL_W'(col);
            vt[k].e_taps = '0;
            vt[k].e_tv   = '0;
            for (int j = 1; j <= NUM_TAPS; j++) begin
                if (line >= j) begin
                    vt[k].e_taps[(j-1)*DATA_W +: DATA_W] = DATA_W'((line-j)*16 + col);
                    vt[k].e_tv[j-1] = 1'b1;
                end
            end
        end

        for (int s = 0; s < NUM_TAPS; s++)
            for (int c = 0; c < LINE_LEN; c++) m_mem[s][c] = '0;
        model_reset();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_sol   = 1'b0;
        bus.in_sof   = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_pix", 64'(bus.out_pix), 64'(0));
        chk("rst_taps", 64'(bus.out_taps), 64'(0));
        chk("rst_tv", 64'(bus.out_taps_valid), 64'(0));
        chk("rst_col", 64'(bus.out_col), 64'(0));
        chk("rst_short", 64'(bus.short_line), 64'(0));
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // continuous frame, then same frame with alternating idle cycles
        run_table(1'b0);
        run_table(1'b1);

        // short line 1: sol arrives with its 6th pixel
        step(1'b1, DATA_W'(8'h00), 1'b0, 1'b1);
        send_line(0, 1, LINE_LEN-1);
        step(1'b1, DATA_W'(8'h10), 1'b1, 1'b0);
        send_line(1, 1, 4);
        shorts = 0;
        step(1'b1, DATA_W'(8'h20), 1'b1, 1'b0);
        if (bus.short_line) shorts++;
        chk("short_pulse", 64'(bus.short_line), 64'(1));
        chk("short_col0", 64'(bus.out_col), 64'(0));
        chk("short_tap1_c0", 64'(tap(1)), 64'(8'h10));
        for (int c = 1; c < LINE_LEN; c++) begin
            step(1'b1, DATA_W'(8'h20 + c), 1'b0, 1'b0);
            if (bus.short_line) shorts++;
            if (c <= 4) chk("short_tap1", 64'(tap(1)), 64'(8'h10 + c));
        end
        chk("short_count", 64'(shorts), 64'(1));

        // sof mid-line after 4 lines
        step(1'b1, DATA_W'(8'h00), 1'b0, 1'b1);
        send_line(0, 1, LINE_LEN-1);
        for (int l = 1; l < 4; l++) send_line(l, 0, LINE_LEN);
        send_line(4, 0, 3);
        step(1'b1, DATA_W'(8'h00), 1'b0, 1'b1);
        chk("sof_no_short", 64'(bus.short_line), 64'(0));
        chk("sof_col", 64'(bus.out_col), 64'(0));
        chk("sof_tv", 64'(bus.out_taps_valid), 64'(0));
        send_line(0, 1, LINE_LEN-1);
        send_line(1, 0, 1);
        chk("sof_tv_l1", 64'(bus.out_taps_valid), 64'(3'b001));
        send_line(1, 1, LINE_LEN-1);
        send_line(2, 0, 1);
        chk("sof_tv_l2", 64'(bus.out_taps_valid), 64'(3'b011));
        send_line(2, 1, LINE_LEN-1);

        // six lines: two wraps of the write pointer
        step(1'b1, DATA_W'(8'h00), 1'b0, 1'b1);
        send_line(0, 1, LINE_LEN-1);
        for (int l = 1; l < 5; l++) send_line(l, 0, LINE_LEN);
        send_line(5, 0, 3);
        chk("rot_tap1", 64'(tap(1)), 64'(8'h42));
        chk("rot_tap2", 64'(tap(2)), 64'(8'h32));
        chk("rot_tap3", 64'(tap(3)), 64'(8'h22));
        send_line(5, 3, LINE_LEN-3);

        // async reset mid-line 2
        step(1'b1, DATA_W'(8'h00), 1'b0, 1'b1);
        send_line(0, 1, LINE_LEN-1);
        send_line(1, 0, LINE_LEN);
        send_line(2, 0, 4);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(bus.out_valid), 64'(0));
        chk("arst_tv", 64'(bus.out_taps_valid), 64'(0));
        chk("arst_short", 64'(bus.short_line), 64'(0));
        bus.in_valid = 1'b0;
        bus.in_sol   = 1'b0;
        bus.in_sof   = 1'b0;
        model_reset();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, DATA_W'(8'h70), 1'b1, 1'b0);
        chk("post_rst_col", 64'(bus.out_col), 64'(0));
        chk("post_rst_tv", 64'(bus.out_taps_valid), 64'(0));
        send_line(7, 1, LINE_LEN-1);
        send_line(8, 0, 2);

        // random traffic
        step(1'b1, DATA_W'($urandom), 1'b0, 1'b1);
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 3) != 0),
                 DATA_W'($urandom),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 79) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
